alu_operand_issue: RTL and testbench

- Execute-issue stage sitting directly upstream of the softcore ALU.
- Accepts decoded ALU micro-ops over a valid/ready handshake and reads operands from the register file.
- Resolves RAW hazards by forwarding from the ALU output (EX) and from writeback (WB).
- Presents registered a, b and op to the combinational ALU, plus destination info for the downstream writeback stage.

---
 rtl/alu_operand_issue.sv | 116 +++++++++++
 tb/tb_alu_operand_issue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// Execute-issue stage in front of the softcore ALU.
// Accepts decoded ALU micro-ops over valid/ready and reads the register file.
// RAW hazards are resolved by forwarding from the ALU output (EX) and from writeback (WB).
// Registered a/b/op feed the combinational ALU; rd/we travel with the op to writeback.
module alu_operand_issue #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_we,
  input  logic               in_use_imm,
  input  logic [DATA_W-1:0]  in_imm,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_we,
  output logic [31:0]        stall_cnt
);

  logic              accept;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] rs2_val;

  // Picks the freshest value of a source register.
  // x0 always reads zero, even when EX or WB claim to write it.
  // EX is younger than WB, so EX wins when both target the same register.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [RADDR_W-1:0] rs,
    input logic [DATA_W-1:0]  rf_val,
    input logic               exv,
    input logic               exw,
    input logic [RADDR_W-1:0] exrd,
    input logic [DATA_W-1:0]  exres,
    input logic               wbv,
    input logic [RADDR_W-1:0] wbrd,
    input logic [DATA_W-1:0]  wbdat
  );
    logic [DATA_W-1:0] r;
    if (rs == '0)
      r = '0;
    else if (exv && exw && (exrd == rs))
      r = exres;
    else if (wbv && (wbrd == rs))
      r = wbdat;
    else
      r = rf_val;
    return r;
  endfunction

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;
  assign in_ready  = !flush && (!ex_valid || ex_ready);
  assign accept    = in_valid && in_ready;

  // Resolve both operands; b is replaced by the immediate when requested.
  always_comb begin
    opnd_a  = resolve(in_rs1, rf_rdata1, ex_valid, ex_we, ex_rd, alu_result,
                      wb_valid, wb_rd, wb_data);
    rs2_val = resolve(in_rs2, rf_rdata2, ex_valid, ex_we, ex_rd, alu_result,
                      wb_valid, wb_rd, wb_data);
    opnd_b  = in_use_imm ? in_imm : rs2_val;
  end

  // EX register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      ex_rd    <= '0;
      ex_we    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      alu_a    <= opnd_a;
      alu_b    <= opnd_b;
      alu_op   <= in_op;
      ex_rd    <= in_rd;
      ex_we    <= in_we;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Saturating count of cycles where an offered op could not be taken; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed testbench for alu_operand_issue with a behavioural register file and ALU.
module tb_alu_operand_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic [31:0] stall_cnt;

  logic [31:0] rf [32];
  logic        alu_ovr_en;
  logic [31:0] alu_ovr;
  int          compared;
  int          mismatched;

  alu_operand_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_we(ex_we),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ~a;
      4'b1001: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign rf_rdata1  = rf[rf_raddr1];
  assign rf_rdata2  = rf[rf_raddr2];
  assign alu_result = alu_ovr_en ? alu_ovr : alu_model(alu_a, alu_b, alu_op);

  task automatic set_op(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                        input logic use_imm, input logic [31:0] imm);
    in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_we = we; in_use_imm = use_imm; in_imm = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ex_valid got %h want 0", ex_valid); end
    compared++; if (alu_a !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_alu_a got %h want 0", alu_a); end
    compared++; if (alu_b !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_alu_b got %h want 0", alu_b); end
    compared++; if (alu_op !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_alu_op got %h want 0", alu_op); end
    compared++; if (ex_rd !== 5'd0 || ex_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_we got %h/%h want 0/0", ex_rd, ex_we); end
    compared++; if (stall_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_stall_cnt got %h want 0", stall_cnt); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %h want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    ex_ready = 1'b1;
    set_op(1'b1, 4'b0000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0);
    #1;
    compared++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin mismatched++; $display("[TB] FAIL add_raddr got %h/%h want 01/02", rf_raddr1, rf_raddr2); end
    step();
    compared++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin mismatched++; $display("[TB] FAIL add_operands got %h/%h want 5/3", alu_a, alu_b); end
    compared++; if (alu_op !== 4'b0000 || ex_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL add_op_valid got %h/%h want 0/1", alu_op, ex_valid); end
    compared++; if (alu_result !== 32'd8) begin mismatched++; $display("[TB] FAIL add_result got %h want 8", alu_result); end
    compared++; if (ex_rd !== 5'd3 || ex_we !== 1'b1) begin mismatched++; $display("[TB] FAIL add_rd_we got %h/%h want 3/1", ex_rd, ex_we); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_op(1'b1, 4'b0001, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 32'd0);
    step();
    compared++; if (alu_result !== 32'd2) begin mismatched++; $display("[TB] FAIL b2b_sub_result got %h want 2", alu_result); end
    @(negedge clk);
    set_op(1'b1, 4'b0100, 5'd4, 5'd2, 5'd5, 1'b1, 1'b1, 32'h0000_000A);
    step();
    compared++; if (alu_a !== 32'd2 || alu_b !== 32'h0000_000A) begin mismatched++; $display("[TB] FAIL b2b_xor_operands got %h/%h want 2/a", alu_a, alu_b); end
    compared++; if (alu_op !== 4'b0100 || alu_result !== 32'd8) begin mismatched++; $display("[TB] FAIL b2b_xor_result got op %h res %h want 4/8", alu_op, alu_result); end
  endtask

  task automatic test_forward_priority();
    @(negedge clk);
    set_op(1'b1, 4'b0000, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 32'd0);
    step();
    @(negedge clk);
    alu_ovr_en = 1'b1; alu_ovr = 32'h11;
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h22; rf[6] = 32'h33;
    set_op(1'b1, 4'b0000, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    step();
    compared++; if (alu_a !== 32'h11 || alu_b !== 32'd0) begin mismatched++; $display("[TB] FAIL fwd_ex got %h/%h want 11/0", alu_a, alu_b); end
    @(negedge clk);
    set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    step();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fwd_drain1 got %h want 0", ex_valid); end
    @(negedge clk);
    set_op(1'b1, 4'b0000, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    step();
    compared++; if (alu_a !== 32'h22) begin mismatched++; $display("[TB] FAIL fwd_wb got %h want 22", alu_a); end
    @(negedge clk);
    set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    step();
    @(negedge clk);
    wb_valid = 1'b0;
    set_op(1'b1, 4'b0000, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    step();
    compared++; if (alu_a !== 32'h33) begin mismatched++; $display("[TB] FAIL fwd_rf got %h want 33", alu_a); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    alu_ovr_en = 1'b0;
    set_op(1'b1, 4'b0000, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'd0);
    step();
    @(negedge clk);
    alu_ovr_en = 1'b1; alu_ovr = 32'hFFFF_FFFF;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55; rf[0] = 32'h77;
    set_op(1'b1, 4'b0000, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 32'd0);
    step();
    compared++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin mismatched++; $display("[TB] FAIL x0_operands got %h/%h want 0/0", alu_a, alu_b); end
    @(negedge clk);
    alu_ovr_en = 1'b0; wb_valid = 1'b0; rf[0] = 32'd0;
    set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    step();
  endtask

  task automatic test_stall();
    @(negedge clk);
    set_op(1'b1, 4'b0000, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'd0);
    step();
    @(negedge clk);
    ex_ready = 1'b0;
    set_op(1'b1, 4'b0001, 5'd2, 5'd1, 5'd10, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      in_rs1 = 5'(i + 11);
      #1;
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_in_ready[%0d] got %h want 0", i, in_ready); end
      step();
      compared++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'b0000) begin mismatched++; $display("[TB] FAIL stall_hold[%0d] got %h/%h/%h want 5/3/0", i, alu_a, alu_b, alu_op); end
    end
    compared++; if (stall_cnt !== 32'd3) begin mismatched++; $display("[TB] FAIL stall_cnt got %0d want 3", stall_cnt); end
    @(negedge clk);
    ex_ready = 1'b1;
    in_rs1 = 5'd2;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_release_ready got %h want 1", in_ready); end
    step();
    compared++; if (alu_a !== 32'd3 || alu_b !== 32'd5 || alu_op !== 4'b0001) begin mismatched++; $display("[TB] FAIL stall_release_op got %h/%h/%h want 3/5/1", alu_a, alu_b, alu_op); end
    compared++; if (stall_cnt !== 32'd3) begin mismatched++; $display("[TB] FAIL stall_cnt_after got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; ex_ready = 1'b0;
    set_op(1'b1, 4'b0010, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'd0);
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_in_ready got %h want 0", in_ready); end
    step();
    compared++; if (ex_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_ex_valid got %h want 0", ex_valid); end
    compared++; if (alu_op !== 4'b0001 || alu_a !== 32'd3) begin mismatched++; $display("[TB] FAIL flush_no_accept got op %h a %h want 1/3", alu_op, alu_a); end
    compared++; if (stall_cnt !== 32'd4) begin mismatched++; $display("[TB] FAIL flush_stall_cnt got %0d want 4", stall_cnt); end
    @(negedge clk);
    flush = 1'b0; ex_ready = 1'b1;
    set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_op(1'b1, 4'b1010, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 32'd0);
    step();
    compared++; if (ex_valid !== 1'b1 || alu_result !== 32'd15) begin mismatched++; $display("[TB] FAIL mul_issue got v %h res %h want 1/f", ex_valid, alu_result); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (ex_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'd0) begin mismatched++; $display("[TB] FAIL async_reset_ex got %h/%h/%h/%h want 0/0/0/0", ex_valid, alu_a, alu_b, alu_op); end
    compared++; if (ex_rd !== 5'd0 || ex_we !== 1'b0 || stall_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL async_reset_misc got %h/%h/%0d want 0/0/0", ex_rd, ex_we, stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + 32'(i);
    rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd3; rf[4] = 32'h99;
    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    alu_ovr_en = 1'b0; alu_ovr = 32'd0;
    set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    test_reset();
    test_add();
    test_back_to_back();
    test_forward_priority();
    test_x0();
    test_stall();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
